uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of rxd synchronizer flops, legal values 2..3.
REQ-002 SHALL use a single clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports:
- pclk  in  1  clock.
- presetn  in  1  async active-low reset.
- rxd  in  1  serial line, asynchronous to pclk, idle high.
- voting_edge  in  1  one-cycle pulse marking a vote point; 3 per bit period.
- sample_edge  in  1  one-cycle pulse marking the bit-decision point; 1 per bit period, after the 3 votes.
- rx_en  in  1  receiver enable.
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- pen  in  1  parity enable.
- eps  in  1  even parity select.
- sp  in  1  stick parity.
- sample_clk_clr  out  1  one-cycle pulse that realigns the bit-timing generator.
- rx_data  out  8  received word, LSB-aligned, unused MSBs 0.
- rx_valid  out  1  one-cycle pulse: frame complete.
- parity_err  out  1  parity error for the frame in rx_data.
- frame_err  out  1  stop bit sampled 0.
- break_err  out  1  break condition detected.
- rx_busy  out  1  high in every state except IDLE.

Function
REQ-004 SHALL pass rxd through SYNC_STAGES flops (reset value 1); all logic SHALL use the synchronized value rxs and its one-cycle-delayed copy rxs_d (reset value 1).
REQ-005 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-006 SHALL, in IDLE with rx_en=1 and rxs_d=1, rxs=0, assert sample_clk_clr for exactly one cycle and enter START on the next cycle.
REQ-007 SHALL latch wls/pen/eps/sp on start detection and hold them constant for the frame.
REQ-008 SHALL keep a 3-entry vote register, cleared on entry to each bit and after each sample_edge; each voting_edge shifts in rxs.
REQ-009 SHALL resolve each bit at sample_edge as the majority (>=2 of 3) of the votes.
REQ-010 SHALL include a vote coincident with sample_edge in that bit's majority.
REQ-011 START at sample_edge: majority 0 -> DATA with bit counter 0; majority 1 -> IDLE (false start, no rx_valid).
REQ-012 DATA: shift bits in LSB first at each sample_edge; after bit (wls+5) -> PARITY if pen=1, else STOP.
REQ-013 PARITY at sample_edge, expected bit:
- sp=1: ~eps.
- sp=0, eps=1: XOR of data bits (even).
- sp=0, eps=0: XNOR of data bits (odd).
- Mismatch sets the parity error for this frame.
REQ-014 STOP: at sample_edge, majority 0 sets frame error; the state returns to IDLE in the same update.
REQ-015 SHALL flag break when all data bits, the parity bit (if enabled) and the stop bit all resolved 0; break SHALL also set frame error.
REQ-016 SHALL check only one stop bit regardless of configured stop-bit count.
REQ-017 SHALL update rx_data, parity_err, frame_err and break_err, and pulse rx_valid, in the cycle after the stop-bit sample_edge; they are registered and coincident.
REQ-018 SHALL hold rx_data and the error flags until the next rx_valid.
REQ-019 SHALL, after a frame, detect the next start only on a fresh 1->0 transition of rxs; a line held low after a break SHALL NOT retrigger.
REQ-020 SHALL, on rx_en=0 in any non-IDLE state, return to IDLE next cycle with no rx_valid and outputs unchanged.
REQ-021 SHALL ignore voting_edge/sample_edge in IDLE.

Reset
REQ-022 SHALL, on presetn low, immediately force:
- state IDLE, rx_data 0x00, all flags 0, sample_clk_clr 0, rx_valid 0.
- vote register and bit counter 0; synchronizer and rxs_d 1.
REQ-023 SHALL, on reset mid-frame, discard the partial frame and never emit rx_valid for it.

Verification
REQ-024 8N1 (wls=11, pen=0), frame 0xA5, stop 1 -> one sample_clk_clr at start; rx_valid once; rx_data=0xA5; all errors 0.
REQ-025 7-bit even parity (wls=10, pen=1, eps=1, sp=0), data 0x41, parity bit 1 (wrong) -> rx_data=0x41, parity_err=1, frame_err=0.
REQ-026 8N1, data 0x3C, stop bit 0 -> rx_data=0x3C, frame_err=1, break_err=0; then line low->high->low starts next frame normally.
REQ-027 Line low for 12 bit periods, 8N1 -> one rx_valid, rx_data=0x00, frame_err=1, break_err=1; no second frame until the line returns high and falls again.
REQ-028 rxd low for only the first of the three start-bit votes -> START majority 1, back to IDLE, no rx_valid, rx_busy low.
REQ-029 rx_en=0 mid-DATA, then presetn low mid-frame on a second frame -> no rx_valid for either frame; after reset all outputs are at reset values and rx_busy=0.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver with majority-vote bit recovery.
//
// The serial line is synchronised into the pclk domain and a start bit is
// detected on a 1->0 transition of the synchronised line. An external
// bit-timing generator supplies three vote pulses (voting_edge) and one
// decision pulse (sample_edge) per bit period. Each bit is the majority of
// its three votes. Word length, parity enable, even/odd parity and stick
// parity are captured at start detection and held for the whole frame.
//
// Ports:
//   pclk           in   clock
//   presetn        in   asynchronous active-low reset
//   rxd            in   serial line (asynchronous, idle high)
//   voting_edge    in   vote-point pulse, three per bit period
//   sample_edge    in   bit-decision pulse, one per bit period
//   rx_en          in   receiver enable; dropping it aborts a frame
//   wls[1:0]       in   word length: 00=5, 01=6, 10=7, 11=8 data bits
//   pen            in   parity enable
//   eps            in   even parity select
//   sp             in   stick parity
//   sample_clk_clr out  one-cycle pulse realigning the bit-timing generator
//   rx_data[7:0]   out  received word, LSB aligned, unused MSBs zero
//   rx_valid       out  one-cycle pulse: a frame has completed
//   parity_err     out  parity error for the frame in rx_data
//   frame_err      out  stop bit resolved to 0
//   break_err      out  whole frame (data, parity, stop) resolved to 0
//   rx_busy        out  receiver is inside a frame
//
// SYNC_STAGES selects the synchroniser depth; legal values are 2 and 3.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       rxd,
    input  logic       voting_edge,
    input  logic       sample_edge,
    input  logic       rx_en,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic       sample_clk_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Register state (q) and next-state (d)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic                   rxs_d_q, rxs_d_d;
    state_t                 state_q, state_d;

    logic [2:0]             vote_q,    vote_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q,   shift_d;

    // Frame configuration captured at start detection
    logic [1:0]             wls_q, wls_d;
    logic                   pen_q, pen_d;
    logic                   eps_q, eps_d;
    logic                   sp_q,  sp_d;

    // Per-frame accumulators, transferred to the outputs at the stop bit
    logic                   par_err_q, par_err_d;
    logic                   all_zero_q, all_zero_d;

    // Registered outputs
    logic                   sample_clk_clr_q, sample_clk_clr_d;
    logic [7:0]             rx_data_q,        rx_data_d;
    logic                   rx_valid_q,       rx_valid_d;
    logic                   parity_err_q,     parity_err_d;
    logic                   frame_err_q,      frame_err_d;
    logic                   break_err_q,      break_err_d;

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic       rxs;
    logic [2:0] vote_next;
    logic       maj;
    logic       last_bit;
    logic       exp_par;
    logic       start_det;

    // Synchronised line is the last synchroniser flop.
    assign rxs = sync_q[SYNC_STAGES-1];

    // A vote arriving in the same cycle as sample_edge must take part in
    // the decision, so the majority looks at the post-shift vote vector.
    assign vote_next = voting_edge ? {vote_q[1:0], rxs} : vote_q;
    assign maj       = (vote_next[0] & vote_next[1]) |
                       (vote_next[0] & vote_next[2]) |
                       (vote_next[1] & vote_next[2]);

    // Bit index of the final data bit is wls+4, i.e. {1, wls}.
    assign last_bit  = (bit_cnt_q == {1'b1, wls_q});

    // Unreceived MSBs of shift_q are zero, so reducing all 8 bits gives
    // the parity of the received word only.
    assign exp_par   = sp_q  ? ~eps_q   :
                       eps_q ? ^shift_q : ~(^shift_q);

    // Start only on a fresh falling transition; a line parked low (e.g.
    // after a break) never produces rxs_d=1 with rxs=0.
    assign start_det = rx_en & rxs_d_q & ~rxs;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync_d           = {sync_q[SYNC_STAGES-2:0], rxd};
        rxs_d_d          = rxs;
        state_d          = state_q;
        vote_d           = vote_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        wls_d            = wls_q;
        pen_d            = pen_q;
        eps_d            = eps_q;
        sp_d             = sp_q;
        par_err_d        = par_err_q;
        all_zero_d       = all_zero_q;
        sample_clk_clr_d = 1'b0;
        rx_data_d        = rx_data_q;
        rx_valid_d       = 1'b0;
        parity_err_d     = parity_err_q;
        frame_err_d      = frame_err_q;
        break_err_d      = break_err_q;

        if (state_q == IDLE) begin
            // Timing pulses are ignored while idle; keep votes clean.
            vote_d = 3'b000;
            if (start_det) begin
                sample_clk_clr_d = 1'b1;
                state_d          = START;
                wls_d            = wls;
                pen_d            = pen;
                eps_d            = eps;
                sp_d             = sp;
                bit_cnt_d        = 3'd0;
                shift_d          = 8'h00;
                par_err_d        = 1'b0;
                all_zero_d       = 1'b1;
            end
        end else if (!rx_en) begin
            // Abort: drop the partial frame, leave the outputs untouched.
            state_d = IDLE;
            vote_d  = 3'b000;
        end else begin
            vote_d = vote_next;
            if (sample_edge) begin
                vote_d = 3'b000;
                case (state_q)
                    START: begin
                        bit_cnt_d = 3'd0;
                        // A start bit that resolves high was a glitch.
                        state_d   = maj ? IDLE : DATA;
                    end
                    DATA: begin
                        shift_d[bit_cnt_q] = maj;
                        all_zero_d         = all_zero_q & ~maj;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            state_d = pen_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_err_d  = (maj != exp_par);
                        all_zero_d = all_zero_q & ~maj;
                        state_d    = STOP;
                    end
                    STOP: begin
                        // Only one stop bit is ever checked.
                        state_d      = IDLE;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = par_err_q;
                        frame_err_d  = ~maj;
                        break_err_d  = all_zero_q & ~maj;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q           <= '1;
            rxs_d_q          <= 1'b1;
            state_q          <= IDLE;
            vote_q           <= 3'b000;
            bit_cnt_q        <= 3'd0;
            shift_q          <= 8'h00;
            wls_q            <= 2'b00;
            pen_q            <= 1'b0;
            eps_q            <= 1'b0;
            sp_q             <= 1'b0;
            par_err_q        <= 1'b0;
            all_zero_q       <= 1'b0;
            sample_clk_clr_q <= 1'b0;
            rx_data_q        <= 8'h00;
            rx_valid_q       <= 1'b0;
            parity_err_q     <= 1'b0;
            frame_err_q      <= 1'b0;
            break_err_q      <= 1'b0;
        end else begin
            sync_q           <= sync_d;
            rxs_d_q          <= rxs_d_d;
            state_q          <= state_d;
            vote_q           <= vote_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            wls_q            <= wls_d;
            pen_q            <= pen_d;
            eps_q            <= eps_d;
            sp_q             <= sp_d;
            par_err_q        <= par_err_d;
            all_zero_q       <= all_zero_d;
            sample_clk_clr_q <= sample_clk_clr_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            parity_err_q     <= parity_err_d;
            frame_err_q      <= frame_err_d;
            break_err_q      <= break_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sample_clk_clr = sample_clk_clr_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign parity_err     = parity_err_q;
    assign frame_err      = frame_err_q;
    assign break_err      = break_err_q;
    assign rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// A bit-timing generator (16 clocks per bit, votes at counts 6/7/8, decision
// at count 8) is realigned by sample_clk_clr. Frames are described at bit
// level; a frame-level model predicts the received word and flags, which a
// compare process checks on every rx_valid, while it also checks that the
// outputs hold between frames. Directed tests pin literal values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int P = 16;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       rxd;
    logic       voting_edge;
    logic       sample_edge;
    logic       rx_en;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       sample_clk_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_err;
    logic       rx_busy;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .rxd            (rxd),
        .voting_edge    (voting_edge),
        .sample_edge    (sample_edge),
        .rx_en          (rx_en),
        .wls            (wls),
        .pen            (pen),
        .eps            (eps),
        .sp             (sp),
        .sample_clk_clr (sample_clk_clr),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .break_err      (break_err),
        .rx_busy        (rx_busy)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       be;
    } exp_t;

    int   checks    = 0;
    int   failures  = 0;
    int   valid_cnt = 0;
    int   clr_cnt   = 0;
    int   tcnt      = 0;
    exp_t exp_q[$];
    exp_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame-level expectation straight from the framing rules.
    function automatic exp_t model(input logic [7:0] data, input int nbits, input logic p_en,
                                   input logic e_sel, input logic s_par, input logic par_bit,
                                   input logic stop_bit);
        int   ones;
        logic want;
        exp_t e;
        ones = 0;
        e    = '0;
        for (int i = 0; i < nbits; i++) begin
            e.data[i] = data[i];
            if (data[i]) ones++;
        end
        if (s_par)      want = ~e_sel;
        else if (e_sel) want = (ones % 2 == 1);
        else            want = (ones % 2 == 0);
        e.pe = p_en && (par_bit != want);
        e.fe = ~stop_bit;
        e.be = (e.data == 8'h00) && (!p_en || !par_bit) && !stop_bit;
        return e;
    endfunction

    // Bit-timing generator, realigned by sample_clk_clr.
    initial begin
        voting_edge = 1'b0;
        sample_edge = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (sample_clk_clr) tcnt = 0;
            else                tcnt = (tcnt + 1) % P;
            voting_edge = (tcnt >= 6 && tcnt <= 8);
            sample_edge = (tcnt == 8);
        end
    end

    // Compare process: every cycle, outputs either carry the next expected
    // frame (on rx_valid) or hold the previous one.
    initial begin
        exp_t e;
        held = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                held = '0;
            end else begin
                if (sample_clk_clr) clr_cnt++;
                if (exp_q.size() == 0) check("spurious_rx_valid", {31'd0, rx_valid}, 32'd0);
                if (rx_valid && exp_q.size() != 0) begin
                    valid_cnt++;
                    e = exp_q.pop_front();
                    check("frame_data",       {24'd0, rx_data},   {24'd0, e.data});
                    check("frame_parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                    check("frame_frame_err",  {31'd0, frame_err},  {31'd0, e.fe});
                    check("frame_break_err",  {31'd0, break_err},  {31'd0, e.be});
                    held = e;
                end else if (!rx_valid) begin
                    check("outputs_hold", {21'd0, rx_data, parity_err, frame_err, break_err},
                          {21'd0, held.data, held.pe, held.fe, held.be});
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (P) tick();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n * P) tick();
    endtask

    // Sends a full frame and queues its expectation. Configuration inputs
    // are inverted after the start bit; the receiver must use the latched set.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic pb, input logic sb);
        int n;
        n   = int'(w) + 5;
        wls = w; pen = p; eps = e; sp = s;
        exp_q.push_back(model(data, n, p, e, s, pb, sb));
        drive_bit(1'b0);
        wls = ~w; pen = ~p; eps = ~e; sp = ~s;
        for (int i = 0; i < n; i++) drive_bit(data[i]);
        if (p) drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic check_outputs(input string name, input logic [7:0] d, input logic pe,
                                 input logic fe, input logic be);
        check({name, "_data"}, {24'd0, rx_data}, {24'd0, d});
        check({name, "_flags"}, {29'd0, parity_err, frame_err, break_err}, {29'd0, pe, fe, be});
    endtask

    initial begin
        int v0;
        int c0;
        presetn = 1'b0;
        rxd     = 1'b1;
        rx_en   = 1'b1;
        wls     = 2'b11;
        pen     = 1'b0;
        eps     = 1'b0;
        sp      = 1'b0;
        repeat (3) tick();
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_ctrl", {29'd0, rx_valid, sample_clk_clr, rx_busy}, 32'd0);
        presetn = 1'b1;
        idle(2);
        check("post_reset_ctrl", {29'd0, rx_valid, sample_clk_clr, rx_busy}, 32'd0);

        // 8N1 0xA5
        v0 = valid_cnt; c0 = clr_cnt;
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("a5_valid_count", valid_cnt - v0, 1);
        check("a5_clr_count",   clr_cnt - c0, 1);
        check_outputs("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5_busy", {31'd0, rx_busy}, 32'd0);

        // 7E1, 0x41 with wrong parity bit 1
        send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        check_outputs("7e1_bad", 8'h41, 1'b1, 1'b0, 1'b0);

        // Frame error, then a normal frame after low->high->low
        v0 = valid_cnt; c0 = clr_cnt;
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_outputs("3c_ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_outputs("5a_after_ferr", 8'h5A, 1'b0, 1'b0, 1'b0);
        check("ferr_valid_count", valid_cnt - v0, 2);
        check("ferr_clr_count",   clr_cnt - c0, 2);

        // Parity modes
        send_frame(8'h13, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // 5O1 correct
        idle(1);
        check_outputs("5o1_ok", 8'h13, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   // stick 0, sent 1
        idle(1);
        check_outputs("stick0_bad", 8'h30, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // stick 1, sent 1
        idle(1);
        check_outputs("stick1_ok", 8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // 8E1 correct
        idle(1);
        send_frame(8'h81, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // 8O1 wrong
        idle(1);
        check_outputs("8o1_bad", 8'h81, 1'b1, 1'b0, 1'b0);

        // Break: line low for 12 bit periods, 8N1
        v0 = valid_cnt; c0 = clr_cnt;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        exp_q.push_back(model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rxd = 1'b0;
        repeat (12 * P) tick();
        check("break_valid_count", valid_cnt - v0, 1);
        check("break_clr_count",   clr_cnt - c0, 1);
        check_outputs("break", 8'h00, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("break_no_retrigger", valid_cnt - v0, 1);
        send_frame(8'hC3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_outputs("after_break", 8'h03, 1'b0, 1'b0, 1'b0);

        // Break with 5E1: data, parity and stop all 0
        wls = 2'b00; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        exp_q.push_back(model(8'h00, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        rxd = 1'b0;
        repeat (10 * P) tick();
        idle(2);
        check_outputs("break_5e1", 8'h00, 1'b0, 1'b1, 1'b1);

        // False start: low only for the first start-bit vote
        v0 = valid_cnt; c0 = clr_cnt;
        wls = 2'b11; pen = 1'b0;
        rxd = 1'b0;
        repeat (5) tick();
        check("glitch_busy_in_start", {31'd0, rx_busy}, 32'd1);
        repeat (3) tick();
        idle(2);
        check("glitch_clr_count",   clr_cnt - c0, 1);
        check("glitch_valid_count", valid_cnt - v0, 0);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);

        // rx_en dropped mid-DATA
        v0 = valid_cnt; c0 = clr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx_en = 1'b0;
        tick();
        tick();
        check("rxen_abort_busy", {31'd0, rx_busy}, 32'd0);
        for (int i = 4; i < 8; i++) drive_bit(i[0]);
        drive_bit(1'b1);
        idle(2);
        rx_en = 1'b1;
        idle(1);
        check_outputs("rxen_abort_hold", 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("reset_frame_busy", {31'd0, rx_busy}, 32'd1);
        presetn = 1'b0;
        rxd     = 1'b1;
        repeat (3) tick();
        check_outputs("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("midframe_reset_ctrl", {29'd0, rx_valid, sample_clk_clr, rx_busy}, 32'd0);
        presetn = 1'b1;
        idle(3);
        check_outputs("after_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("after_reset_ctrl", {29'd0, rx_valid, sample_clk_clr, rx_busy}, 32'd0);
        check("abort_valid_count", valid_cnt - v0, 0);
        check("abort_clr_count",   clr_cnt - c0, 2);

        // A clean frame still works after reset
        send_frame(8'h69, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_outputs("post_reset_frame", 8'h69, 1'b0, 1'b0, 1'b0);
        check("pending_frames", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
